// File: rtl/serial_word_pkg.sv
// Shared definitions for the single-wire word link: FSM states, default
// payload width and the line levels that frame a word.
package serial_word_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int   DEFAULT_WIDTH = 33;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/serial_word_shifter.sv
// Datapath for the word receiver: LSB-first shift register, received-bit
// counter and running XOR of the payload bits.
// Build option: SERIAL_WORD_PARITY_EN adds the running parity output.
module serial_word_shifter
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
`ifdef SERIAL_WORD_PARITY_EN
  output logic             parity,
`endif
  output logic             last_bit,
  output logic [WIDTH-1:0] word
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
    end else if (shift) begin
      r_shreg <= {bit_in, r_shreg[WIDTH-1:1]};
    end
  end

  // Bit counter: cleared at the start bit, advanced once per payload bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SERIAL_WORD_PARITY_EN
  logic r_par;

  // Running even parity over the payload bits of the current frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (clear) begin
      r_par <= 1'b0;
    end else if (shift) begin
      r_par <= r_par ^ bit_in;
    end
  end

  assign parity = r_par;
`endif

  // High while the bit being shifted in is the final payload bit.
  assign last_bit = (r_cnt == LAST_CNT);
  assign word     = r_shreg;

endmodule

// File: rtl/serial_word_receiver.sv
// Receiving end of the single-wire word link. Recovers WIDTH-bit words sent
// as start(1), payload LSB first, optional even parity, stop(0), one bit per
// clock, and reports each word with a one-cycle valid pulse.
// Build option: SERIAL_WORD_PARITY_EN enables the parity bit and parity_error.
module serial_word_receiver
  import serial_word_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_error,
  output logic             parity_error,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_clear;
  logic             w_shift;
  logic             w_load;
  logic             w_ferr;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ferr;

`ifdef SERIAL_WORD_PARITY_EN
  logic w_par;
  logic r_par_mis;
  logic r_perr;
`endif

  serial_word_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .clear    (w_clear),
    .shift    (w_shift),
    .bit_in   (serial_in),
`ifdef SERIAL_WORD_PARITY_EN
    .parity   (w_par),
`endif
    .last_bit (w_last_bit),
    .word     (w_word)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the datapath and output strobes for this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (serial_in == START_LEVEL) begin
          w_clear     = 1'b1;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_shift = 1'b1;
        if (w_last_bit) begin
`ifdef SERIAL_WORD_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef SERIAL_WORD_PARITY_EN
      PARITY: begin
        w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (serial_in == STOP_LEVEL) begin
          w_load = 1'b1;
        end else begin
          w_ferr = 1'b1;
        end
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered word and one-cycle status pulses, updated at the stop bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_load;
      r_ferr  <= w_ferr;
      if (w_load) begin
        r_data <= w_word;
      end
    end
  end

`ifdef SERIAL_WORD_PARITY_EN
  // Latch the parity comparison, then report it alongside the valid pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_par_mis <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (r_state == PARITY) begin
        r_par_mis <= serial_in ^ w_par;
      end
      r_perr <= w_load & r_par_mis;
    end
  end

  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_error = r_ferr;
  assign busy        = (r_state != IDLE);

endmodule
